// File: rtl/aes_round_sequencer_if.sv
// rtl/aes_round_sequencer_if.sv - request/response channels of the AES round sequencer
interface aes_round_sequencer_if;
    logic         req_valid;
    logic         req_ready;
    logic         req_decrypt;
    logic [0:127] req_data;
    logic         resp_valid;
    logic         resp_ready;
    logic [0:127] resp_data;

    modport master (
        output req_valid, req_decrypt, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_decrypt, req_data, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - steps one block through a shared combinational AES round datapath
module aes_round_sequencer #(
    parameter int Nk     = 4,
    parameter int Nr     = Nk + 6,
    parameter int KEYS_W = 128 * (Nr + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_round_sequencer_if.slave host,
    input  logic [0:KEYS_W-1]    keys,
    output logic [0:127]         rnd_state,
    output logic [0:127]         rnd_key,
    output logic [1:0]           rnd_kind,
    output logic                 rnd_inv,
    input  logic [0:127]         rnd_result,
    output logic                 busy,
    output logic [3:0]           round_cnt
);

    typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} seq_state_t;

    seq_state_t   cur_state;
    seq_state_t   nxt_state;
    logic [0:127] state_reg;
    logic [0:127] resp_data_q;
    logic         resp_valid_q;
    logic         mode;
    logic         req_ready;
    logic [3:0]   key_idx;

    always_ff @(posedge clk) begin
        if (reset) cur_state <= IDLE;
        else       cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE:    if (host.req_valid) nxt_state = INIT;
            INIT:    nxt_state = (Nr > 1) ? ROUND : FINAL;
            ROUND:   if (round_cnt == 4'(Nr - 1)) nxt_state = FINAL;
            FINAL:   nxt_state = DONE;
            DONE:    if (host.resp_ready) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (cur_state == IDLE);
        busy      = (cur_state != IDLE);
        rnd_kind  = 2'd0;
        case (cur_state)
            ROUND:   rnd_kind = 2'd1;
            FINAL:   rnd_kind = 2'd2;
            default: rnd_kind = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
            round_cnt    <= 4'd0;
            mode         <= 1'b0;
        end else begin
            case (cur_state)
                IDLE: if (host.req_valid) begin
                    state_reg <= host.req_data;
                    mode      <= host.req_decrypt;
                    round_cnt <= 4'd0;
                end
                INIT: begin
                    state_reg <= rnd_result;
                    round_cnt <= 4'd1;
                end
                ROUND: begin
                    state_reg <= rnd_result;
                    round_cnt <= round_cnt + 4'd1;
                end
                FINAL: begin
                    resp_data_q  <= rnd_result;
                    resp_valid_q <= 1'b1;
                end
                DONE: if (host.resp_ready) resp_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Decryption walks the key schedule backwards; idle states park on the first key of the mode.
    always_comb begin
        if (cur_state == IDLE || cur_state == DONE)
            key_idx = mode ? 4'(Nr) : 4'd0;
        else
            key_idx = mode ? 4'(Nr) - round_cnt : round_cnt;
        rnd_key = '0;
        for (int r = 0; r <= Nr; r++) begin
            if (key_idx == 4'(r)) rnd_key = keys[r*128 +: 128];
        end
    end

    assign rnd_state       = state_reg;
    assign rnd_inv         = mode;
    assign host.req_ready  = req_ready;
    assign host.resp_valid = resp_valid_q;
    assign host.resp_data  = resp_data_q;

endmodule
